// File: rtl/decoder_3to8_buf.sv
// decoder_3to8_buf: buffered 3:8 one-hot decoder.
//
// Codes are accepted through a valid/ready input handshake, held in a 2-entry
// FIFO and delivered MSB-first decoded (code 0 -> 8'h80 ... code 7 -> 8'h01)
// through a valid/ready output handshake. A free-running counter tallies every
// word delivered to the sink.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_code is presented
//   in_code    in   [2:0] binary code to decode
//   in_ready   out  a code is accepted this cycle (FIFO not full)
//   out_valid  out  out_onehot holds a decoded word
//   out_onehot out  [7:0] decoded word, 8'h00 when out_valid is low
//   out_ready  in   sink consumes the word this cycle
//   occ        out  [1:0] FIFO occupancy, 0..2
//   dec_count  out  [CNT_W-1:0] words delivered, wraps modulo 2^CNT_W
module decoder_3to8_buf #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [2:0]       in_code,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_onehot,
  input  logic             out_ready,
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] dec_count
);

  // The FIFO is a head/tail register pair: head_q is the word on the output,
  // tail_q is only meaningful when occ_q == 2.
  logic [1:0]       occ_q, occ_d;
  logic [2:0]       head_q, head_d;
  logic [2:0]       tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic push, pop;

  // Handshake outputs come from registered state only, so in_ready never
  // depends on out_ready; a pop from full frees a slot on the next cycle.
  assign in_ready  = (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;

    case (occ_q)
      2'd0: begin
        // Nothing to pop yet; a push lands straight in the head.
        if (push) begin
          head_d = in_code;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = in_code;
        end else if (push) begin
          tail_d = in_code;
          occ_d  = 2'd2;
        end else if (pop) begin
          occ_d  = 2'd0;
        end
      end
      2'd2: begin
        // Full: pushes are refused by in_ready, only a pop can happen.
        if (pop) begin
          head_d = tail_q;
          occ_d  = 2'd1;
        end
      end
      default: begin
        occ_d = 2'd0;
      end
    endcase

    if (pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= 2'd0;
      head_q <= 3'd0;
      tail_q <= 3'd0;
      cnt_q  <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // MSB-first decode: code 0 sets bit 7, code 7 sets bit 0.
  always_comb begin
    out_onehot = 8'h00;
    if (out_valid) begin
      out_onehot = 8'h80 >> head_q;
    end
  end

  assign occ       = occ_q;
  assign dec_count = cnt_q;

endmodule

// File: tb/tb_decoder_3to8_buf.sv
module tb_decoder_3to8_buf;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_code;
  logic       out_ready;

  logic       in_ready, out_valid;
  logic [7:0] out_onehot;
  logic [1:0] occ;
  logic [7:0] dec_count;

  // Second instance with a 3-bit counter for the wrap check; it sees the
  // same stimulus, only its counter is observed.
  logic       in_ready3, out_valid3;
  logic [7:0] out_onehot3;
  logic [1:0] occ3;
  logic [2:0] dec_count3;

  int checks = 0;
  int errors = 0;

  decoder_3to8_buf #(.CNT_W(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_code    (in_code),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_onehot (out_onehot),
    .out_ready  (out_ready),
    .occ        (occ),
    .dec_count  (dec_count)
  );

  decoder_3to8_buf #(.CNT_W(3)) u_dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_code    (in_code),
    .in_ready   (in_ready3),
    .out_valid  (out_valid3),
    .out_onehot (out_onehot3),
    .out_ready  (out_ready),
    .occ        (occ3),
    .dec_count  (dec_count3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_dec [8];

  initial begin
    exp_dec = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_code   = 3'd0;
    out_ready = 1'b0;

    // Reset asserted between edges takes effect immediately.
    #12;
    rst_n = 1'b0;
    #1;
    chk("rst_onehot", 32'(out_onehot), 32'h00);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(dec_count), 32'd0);
    chk("rst_occ", 32'(occ), 32'd0);
    step();
    rst_n = 1'b1;

    // Exhaustive decode, streaming with out_ready held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_code = 3'(i);
      step();
      chk($sformatf("dec_code%0d", i), 32'(out_onehot), 32'(exp_dec[i]));
      chk($sformatf("dec_occ%0d", i), 32'(occ), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("dec_drain_valid", 32'(out_valid), 32'd0);
    chk("dec_count8", 32'(dec_count), 32'd8);

    // Backpressure: fill, refuse a third push, drain in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 3'b011;
    step();
    chk("bp_first", 32'(out_onehot), 32'h10);
    in_code = 3'b110;
    step();
    chk("bp_occ_full", 32'(occ), 32'd2);
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    in_code = 3'b001;
    step();
    chk("bp_ignored_occ", 32'(occ), 32'd2);
    chk("bp_held", 32'(out_onehot), 32'h10);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_ready_not_comb", 32'(in_ready), 32'd0);
    step();
    chk("bp_second", 32'(out_onehot), 32'h02);
    chk("bp_occ1", 32'(occ), 32'd1);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    step();
    chk("bp_empty_valid", 32'(out_valid), 32'd0);
    chk("bp_empty_onehot", 32'(out_onehot), 32'h00);
    chk("bp_count", 32'(dec_count), 32'd10);

    // Simultaneous push and pop at occupancy 1.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 3'b000;
    step();
    chk("sim_head", 32'(out_onehot), 32'h80);
    in_code   = 3'b111;
    out_ready = 1'b1;
    step();
    chk("sim_occ", 32'(occ), 32'd1);
    chk("sim_next", 32'(out_onehot), 32'h01);
    chk("sim_count", 32'(dec_count), 32'd11);
    in_valid = 1'b0;
    step();
    chk("sim_drain_count", 32'(dec_count), 32'd12);

    // out_ready with nothing buffered changes nothing.
    step();
    chk("noop_count", 32'(dec_count), 32'd12);
    chk("noop_occ", 32'(occ), 32'd0);

    // Mid-operation reset while full and stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 3'b010;
    step();
    in_code = 3'b100;
    step();
    chk("mid_full", 32'(occ), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_occ", 32'(occ), 32'd0);
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_count", 32'(dec_count), 32'd0);
    step();
    chk("mid_no_push", 32'(occ), 32'd0);
    rst_n   = 1'b1;
    in_code = 3'b101;
    step();
    chk("mid_post", 32'(out_onehot), 32'h04);
    chk("mid_post_occ", 32'(occ), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("mid_no_stale", 32'(out_valid), 32'd0);
    chk("mid_post_count", 32'(dec_count), 32'd1);

    // Counter wrap on the 3-bit instance: 9 pops give 1..7, 0, 1.
    rst_n = 1'b0;
    #1;
    chk("wrap_rst", 32'(dec_count3), 32'd0);
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    in_code   = 3'd0;
    step();
    for (int i = 1; i <= 9; i++) begin
      in_code = 3'(i);
      if (i == 9) in_valid = 1'b0;
      step();
      chk($sformatf("wrap_%0d", i), 32'(dec_count3), 32'(i % 8));
    end
    chk("wrap_wide", 32'(dec_count), 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
